// File: rtl/shift_arbiter_pkg.sv
// Shared constants and types for the two-requester shift arbiter.
package shift_arbiter_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned SHAMT_WIDTH = 5;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  typedef struct packed {
    logic                   op;
    logic [DATA_WIDTH-1:0]  data;
    logic [SHAMT_WIDTH-1:0] shamt;
  } shift_req_t;

endpackage

// File: rtl/shift_rr_grant.sv
// Two-way round-robin grant; last_grant_q records the most recently accepted requester.
module shift_rr_grant (
  input  logic clock,
  input  logic reset,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic slot_free_i,
  output logic ready0_o,
  output logic ready1_o
);

  logic last_grant_q, last_grant_d;
  logic grant0, grant1;

  always_comb begin
    // On contention the requester that did not win last time goes first.
    grant0   = valid0_i & (~valid1_i | last_grant_q);
    grant1   = valid1_i & (~valid0_i | ~last_grant_q);
    ready0_o = slot_free_i & grant0 & ~reset;
    ready1_o = slot_free_i & grant1 & ~reset;

    last_grant_d = last_grant_q;
    if (ready0_o) begin
      last_grant_d = 1'b0;
    end else if (ready1_o) begin
      last_grant_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/shift_sll.sv
// Logical left shift unit, zero fill.
module shift_sll (
  input  logic [31:0] data_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] result_o
);

  assign result_o = data_i << shamt_i;

endmodule

// File: rtl/shift_sra.sv
// Arithmetic right shift unit, sign fill from data_i[31].
module shift_sra (
  input  logic [31:0] data_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] result_o
);

  assign result_o = $unsigned($signed(data_i) >>> shamt_i);

endmodule

// File: rtl/shift_arbiter.sv
// Shares one sll/sra shift datapath between two requesters with a one-entry result slot.
module shift_arbiter #(
  parameter int unsigned DATA_WIDTH  = shift_arbiter_pkg::DATA_WIDTH,
  parameter int unsigned SHAMT_WIDTH = shift_arbiter_pkg::SHAMT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic                   req0_op,
  input  logic [DATA_WIDTH-1:0]  req0_data,
  input  logic [SHAMT_WIDTH-1:0] req0_shamt,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic                   req1_op,
  input  logic [DATA_WIDTH-1:0]  req1_data,
  input  logic [SHAMT_WIDTH-1:0] req1_shamt,
  output logic                   resp0_valid,
  input  logic                   resp0_ready,
  output logic                   resp1_valid,
  input  logic                   resp1_ready,
  output logic [DATA_WIDTH-1:0]  resp_data,
  output logic                   busy
);

  import shift_arbiter_pkg::*;

  logic       state_q, state_d;
  logic       owner_q, owner_d;
  shift_req_t opnd_q, opnd_d;
  logic       slot_free;
  logic [DATA_WIDTH-1:0] sll_result, sra_result;

  // The slot frees in the same cycle the owner consumes, so accepts chain with no bubble.
  assign slot_free = (state_q == ST_IDLE) | (owner_q ? resp1_ready : resp0_ready);

  shift_rr_grant u_grant (
    .clock       (clock),
    .reset       (reset),
    .valid0_i    (req0_valid),
    .valid1_i    (req1_valid),
    .slot_free_i (slot_free),
    .ready0_o    (req0_ready),
    .ready1_o    (req1_ready)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    opnd_d  = opnd_q;
    if (req0_ready) begin
      opnd_d  = '{op: req0_op, data: req0_data, shamt: req0_shamt};
      owner_d = 1'b0;
      state_d = ST_HOLD;
    end else if (req1_ready) begin
      opnd_d  = '{op: req1_op, data: req1_data, shamt: req1_shamt};
      owner_d = 1'b1;
      state_d = ST_HOLD;
    end else if (slot_free) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      opnd_q  <= opnd_d;
    end
  end

  shift_sll u_sll (
    .data_i   (opnd_q.data),
    .shamt_i  (opnd_q.shamt),
    .result_o (sll_result)
  );

  shift_sra u_sra (
    .data_i   (opnd_q.data),
    .shamt_i  (opnd_q.shamt),
    .result_o (sra_result)
  );

  // Result is a pure function of the operand register, so it is stable across the hold.
  assign resp_data   = (opnd_q.op == OP_SRA) ? sra_result : sll_result;
  assign resp0_valid = (state_q == ST_HOLD) & ~owner_q;
  assign resp1_valid = (state_q == ST_HOLD) & owner_q;
  assign busy        = (state_q == ST_HOLD);

endmodule
